// File: rtl/grid_serializer.sv
// grid_serializer: snapshots the flattened game-of-life grid on start and
// streams it out one cell per valid/ready transfer, row-major from (0,0).
// Optional build macro GRID_SERIALIZER_ROW_LAST_EN adds a row_last output
// that flags the last column of each row.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; cell_valid and busy low
// SEND  | presenting snapshot cell at (row,col); advances on ready
// DONE  | one-cycle done pulse after the final cell is accepted
module grid_serializer #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*HEIGHT-1:0]   grid_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      cell_out,
  output logic                      cell_valid,
  input  logic                      cell_ready,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic                      frame_last,
`ifdef GRID_SERIALIZER_ROW_LAST_EN
  output logic                      row_last,
`endif
  output logic                      done
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(CELLS);
  localparam int RW    = $clog2(HEIGHT);
  localparam int CW    = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             state;
  logic [CELLS-1:0]   snapshot;
  // Linear index kept alongside row/col so the cell mux needs no multiply.
  logic [IDX_W-1:0]   idx;

  logic [IDX_W-1:0]   idx_nxt;
  logic [RW-1:0]      row_nxt;
  logic [CW-1:0]      col_nxt;
  logic               last_nxt;

  // Position of the cell that follows the one currently presented.
  always_comb begin
    idx_nxt = idx + IDX_W'(1);
    row_nxt = row;
    col_nxt = col + CW'(1);
    if (col == CW'(WIDTH - 1)) begin
      col_nxt = '0;
      row_nxt = row + RW'(1);
    end
    last_nxt = (idx_nxt == IDX_W'(CELLS - 1));
  end

  // Frame sequencing with all outputs registered; nothing moves while a
  // presented cell waits for cell_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      snapshot   <= '0;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      cell_out   <= 1'b0;
      cell_valid <= 1'b0;
      frame_last <= 1'b0;
      done       <= 1'b0;
`ifdef GRID_SERIALIZER_ROW_LAST_EN
      row_last   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snapshot   <= grid_in;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            cell_out   <= grid_in[0];
            cell_valid <= 1'b1;
            busy       <= 1'b1;
            frame_last <= 1'b0;
`ifdef GRID_SERIALIZER_ROW_LAST_EN
            row_last   <= 1'b0;
`endif
            state      <= SEND;
          end
        end
        SEND: begin
          if (cell_ready) begin
            if (frame_last) begin
              cell_valid <= 1'b0;
              frame_last <= 1'b0;
              cell_out   <= 1'b0;
              idx        <= '0;
              row        <= '0;
              col        <= '0;
              done       <= 1'b1;
`ifdef GRID_SERIALIZER_ROW_LAST_EN
              row_last   <= 1'b0;
`endif
              state      <= DONE;
            end else begin
              idx        <= idx_nxt;
              row        <= row_nxt;
              col        <= col_nxt;
              cell_out   <= snapshot[idx_nxt];
              frame_last <= last_nxt;
`ifdef GRID_SERIALIZER_ROW_LAST_EN
              row_last   <= (col_nxt == CW'(WIDTH - 1));
`endif
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/grid_serializer.md
Name: grid_serializer

Overview:
- Reads a snapshot of the flattened game-of-life grid and streams it out one cell per transfer over a valid/ready handshake.
- Sits on the read side of the grid memory: its grid_in connects to the memory's mem_out.
- Feeds the display/debug path, which may apply backpressure at any time.

Parameters:
WIDTH, 4, cells per row (>=2)
HEIGHT, 4, number of rows (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
grid_in  input  WIDTH*HEIGHT  flattened grid; bit index = row*WIDTH + col; bit 0 = row 0, col 0
start  input  1  request a frame readout; sampled only in IDLE
busy  output  1  high while not in IDLE
cell_out  output  1  current cell value
cell_valid  output  1  cell_out/row/col/frame_last are valid
cell_ready  input  1  consumer accepts the current cell
row  output  $clog2(HEIGHT)  row of the current cell
col  output  $clog2(WIDTH)  column of the current cell
frame_last  output  1  current cell is the final cell of the frame (row=HEIGHT-1, col=WIDTH-1)
done  output  1  one-cycle pulse after the last cell is accepted

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - Snapshot register, row, col = 0.
  - All outputs 0.
  - Reset mid-frame aborts immediately; no done pulse.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - cell_valid = 0, busy = 0.
  - On a clock edge with start=1: copy grid_in into the snapshot, set row=0, col=0, go to SEND.
  - cell_valid rises in the cycle after start is sampled (1-cycle latency).
- SEND:
  - cell_valid = 1, busy = 1.
  - cell_out = snapshot[row*WIDTH+col].
  - A transfer occurs on an edge where cell_valid && cell_ready.
  - While cell_ready = 0, all outputs hold stable.
  - On a transfer: col increments. When col = WIDTH-1, col wraps to 0 and row increments.
  - On transfer of the frame_last cell: go to DONE, cell_valid drops the next cycle.
  - Back-to-back transfers are sustained at 1 cell/cycle with cell_ready held high.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle, cell_valid = 0.
  - Then IDLE unconditionally.
- start while in SEND or DONE is ignored; it is not queued.
- grid_in changes after the snapshot do not affect the frame in progress.
- Counter widths: row and col never exceed HEIGHT-1 / WIDTH-1. Non-power-of-2 sizes wrap at the parameter value, not at 2^n.
- Full frame with no backpressure: start edge + WIDTH*HEIGHT transfer cycles + 1 DONE cycle.

Optional Feature:
- Macro: GRID_SERIALIZER_ROW_LAST_EN
- Defined:
  - Adds output port row_last (1 bit).
  - row_last = cell_valid && col == WIDTH-1.
  - Held stable under backpressure like the other outputs.
  - Reset value 0.
- Undefined:
  - Port is absent.
  - All other behaviour is identical.

Test Plan (WIDTH=3, HEIGHT=2 unless noted):
- Reset value: hold reset=0 and toggle clk -> busy, cell_valid, done, cell_out, row, col, frame_last all 0.
- Basic frame: grid_in=6'b101101, start for 1 cycle, cell_ready=1 -> cells 1,0,1,1,0,1 on consecutive cycles with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). frame_last high only on the 6th cell. done pulses once the cycle after.
- Snapshot isolation and ignored start:
  - Start with grid_in=6'b000111.
  - Change grid_in to 6'b111000 and pulse start during SEND.
  - Expect the stream 1,1,1,0,0,0 followed by exactly one done, and no second frame.
- Backpressure: grid_in=6'b000010, cell_ready low for 3 cycles while at (0,1) -> cell_out=1, row=0, col=1, cell_valid=1 stable for all 3 cycles. Advances only when cell_ready=1.
- Reset mid-frame: assert reset after 2 transfers, release, then start with grid_in=6'b100000 -> no done from the aborted frame; the new frame starts at (0,0) and the 6th cell = 1.
- Row-last option (macro defined, WIDTH=5, HEIGHT=3): full frame with cell_ready=1 -> row_last high on transfers 5, 10, 15 only. col wraps 4->0 and row wraps at 2 (no value 3 ever seen).
